mem_write_buffer: RTL and testbench
===================================

MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, posted-write entries (power of two, 2..16); ADDR_W, default 32, word address width; DATA_W, default 32, word data width.
REQ-002 SHALL have ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- ramREN  in  1  upstream read request.
- ramWEN  in  1  upstream write request.
- ramaddr  in  ADDR_W  upstream address.
- ramstore  in  DATA_W  upstream write data.
- ramload  out  DATA_W  read data, valid when ramREN=1 and ramBUSY=0.
- ramBUSY  out  1  request not completed this cycle.
- mem_en  out  1  main-memory request valid.
- mem_wen  out  4  byte write enables to main memory.
- mem_addr  out  ADDR_W  main-memory address.
- mem_wdata  out  DATA_W  main-memory write data.
- mem_rdata  in  DATA_W  main-memory read data.
- mem_busy  in  1  main memory has not completed the held request.
- wb_empty  out  1  buffer holds no entries and FSM is IDLE.
REQ-003 Upstream requests SHALL be held stable by the requester until a cycle with ramBUSY=0.

Function
REQ-004 SHALL hold a circular FIFO of DEPTH {addr,data} entries with head/tail pointers wrapping modulo DEPTH and count 0..DEPTH, width clog2(DEPTH)+1.
REQ-005 full = (count==DEPTH) and empty = (count==0) SHALL both be computed from registered count only; there SHALL be no same-cycle pass-through of a pop into a push.
REQ-006 A write whose ramaddr matches a valid entry SHALL overwrite that entry's data (coalesce) with ramBUSY=0 in the same cycle, even when full, except as in REQ-007.
REQ-007 While the FSM is in DRAIN, the head entry SHALL be excluded from coalescing; a write matching only the head allocates a new entry.
REQ-008 A non-coalescing write SHALL enqueue at tail with ramBUSY=0 the same cycle when not full; when full, ramBUSY=1 and nothing is stored.
REQ-009 A read matching one or more valid entries SHALL return the youngest matching entry's data on ramload with ramBUSY=0 the same cycle (zero-latency forward).
REQ-010 A read missing the buffer SHALL hold ramBUSY=1 until completed from main memory per REQ-013.
REQ-011 ramREN and ramWEN both high SHALL be treated as a read; the write is ignored that cycle.
REQ-012 The FSM SHALL have states IDLE, READ and DRAIN:
- IDLE: a read miss goes to READ and latches ramaddr; otherwise, if not empty, goes to DRAIN; otherwise stays in IDLE. A read miss has priority over draining.
- READ: mem_en=1, mem_wen=4'h0, mem_addr=latched address. In the cycle mem_busy=0: ramload=mem_rdata, ramBUSY=0, next state IDLE.
- DRAIN: mem_en=1, mem_wen=4'hF, mem_addr/mem_wdata=head entry. In the cycle mem_busy=0: pop head (head+1, count-1), next state IDLE.
- A read miss arriving during DRAIN SHALL wait with ramBUSY=1 until the drain completes, then be served via IDLE->READ.
REQ-013 Main-memory request fields SHALL stay constant from entry into READ/DRAIN until the completing cycle; mem_en=0 and mem_wen=0 in IDLE.
REQ-014 A same-cycle push and pop SHALL leave count unchanged and advance both pointers.
REQ-015 When no request is present, ramBUSY SHALL be 0 and ramload SHALL be 0.
REQ-016 A read or write issued in the first cycle after RST deasserts SHALL behave exactly as in IDLE with an empty buffer.

Reset
REQ-017 While RST=1 at a rising edge: count=0, head=tail=0, state=IDLE, latched address=0; entry storage is not cleared.
REQ-018 While RST=1, outputs SHALL be: mem_en=0, mem_wen=0, ramBUSY=1, ramload=0, wb_empty=1. No upstream request is accepted.
REQ-019 RST asserted mid-READ or mid-DRAIN SHALL abandon the operation; buffered writes are lost.

Verification
REQ-020 Write 0x10<-0xA, then read 0x10 the next cycle -> read completes the same cycle with ramload=0xA and mem_en never asserted for the read.
REQ-021 Five writes to distinct addresses (DEPTH=4) with mem_busy held 1 -> first four get ramBUSY=0; the fifth stalls with ramBUSY=1 until the first drain completes (mem_busy=0), then enqueues on a following cycle.
REQ-022 Write 0x20<-1, then 0x20<-2 while idle-full -> count unchanged; a later drain writes 0x20=2 exactly once.
REQ-023 Buffer holds 0x30, read 0x40 miss arrives while IDLE, mem_busy=1 for 3 cycles -> READ issued before the drain, mem_wen=0, ramload=mem_rdata in cycle 4 with ramBUSY=0, then DRAIN of 0x30 with mem_wen=4'hF.
REQ-024 RST pulsed during DRAIN with 3 entries -> next cycle count=0, mem_en=0, wb_empty=1; a subsequent read of a previously buffered address goes to main memory.

Source files
------------

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between a single-port upstream RAM interface and main memory.
// Writes are queued in a small circular FIFO and drained in the background.
// Reads are forwarded from the youngest matching entry, or else fetched from main memory.
module mem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ramREN,
    input  logic              ramWEN,
    input  logic [ADDR_W-1:0] ramaddr,
    input  logic [DATA_W-1:0] ramstore,
    output logic [DATA_W-1:0] ramload,
    output logic              ramBUSY,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    output logic              wb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_raddr;
    logic [ADDR_W-1:0]   r_ent_addr [DEPTH];
    logic [DATA_W-1:0]   r_ent_data [DEPTH];

    logic                w_full;
    logic                w_empty;
    logic                w_rd;
    logic                w_wr;
    logic                w_rd_hit;
    logic [PTR_W-1:0]    w_rd_idx;
    logic                w_wr_hit;
    logic [PTR_W-1:0]    w_wr_idx;
    logic                w_push;
    logic                w_coal;
    logic                w_pop;

    // Full/empty come from the registered count only, so a pop never frees a slot for a push in the same cycle.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A simultaneous read and write is a read; the write is ignored.
    assign w_rd = ramREN;
    assign w_wr = ramWEN & ~ramREN;

    assign w_pop = (r_state == S_DRAIN) && !mem_busy && !RST;

    // Search valid entries from oldest to youngest so the last match wins; the head being drained is not coalescable.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        // NOTE: every variable written here gets a default first, so no latch is inferred on any path.
        v_idx    = '0;
        w_rd_hit = 1'b0;
        w_rd_idx = '0;
        w_wr_hit = 1'b0;
        w_wr_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_ent_addr[v_idx] == ramaddr)) begin
                w_rd_hit = 1'b1;
                w_rd_idx = v_idx;
                if (!((k == 0) && (r_state == S_DRAIN))) begin
                    w_wr_hit = 1'b1;
                    w_wr_idx = v_idx;
                end
            end
        end
    end

    // Upstream response: forward hits, complete misses from main memory, stall otherwise.
    always_comb begin
        ramBUSY = 1'b0;
        ramload = '0;
        w_push  = 1'b0;
        w_coal  = 1'b0;
        if (RST) begin
            ramBUSY = 1'b1;
        end else if (w_rd) begin
            if (w_rd_hit) begin
                ramload = r_ent_data[w_rd_idx];
            end else if ((r_state == S_READ) && !mem_busy) begin
                ramload = mem_rdata;
            end else begin
                ramBUSY = 1'b1;
            end
        end else if (w_wr) begin
            if (w_wr_hit) begin
                w_coal = 1'b1;
            end else if (!w_full) begin
                w_push = 1'b1;
            end else begin
                ramBUSY = 1'b1;
            end
        end
    end

    // Main-memory request decoded from the registered state; fields hold still for the whole access.
    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!RST) begin
            case (r_state)
                S_READ: begin
                    mem_en   = 1'b1;
                    mem_addr = r_raddr;
                end
                S_DRAIN: begin
                    mem_en    = 1'b1;
                    mem_wen   = 4'hF;
                    mem_addr  = r_ent_addr[r_head];
                    mem_wdata = r_ent_data[r_head];
                end
                default: ;
            endcase
        end
    end

    assign wb_empty = RST || (w_empty && (r_state == S_IDLE));

    // FIFO pointers, occupancy and the IDLE/READ/DRAIN controller; a read miss beats draining.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is updated with non-blocking assignments only, so every block sees pre-edge values.
        if (RST) begin
            r_state <= S_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_raddr <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
            case (r_state)
                S_IDLE: begin
                    if (w_rd && !w_rd_hit) begin
                        r_state <= S_READ;
                        r_raddr <= ramaddr;
                    end else if (!w_empty) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_READ:  if (!mem_busy) r_state <= S_IDLE;
                S_DRAIN: if (!mem_busy) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Entry storage: allocate at tail, or overwrite data of a coalesced entry.
    always_ff @(posedge CLK) begin
        // NOTE: entry storage has no reset; validity is defined purely by head and count.
        if (w_push) begin
            r_ent_addr[r_tail] <= ramaddr;
            r_ent_data[r_tail] <= ramstore;
        end
        if (w_coal) begin
            r_ent_data[w_wr_idx] <= ramstore;
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer; expected read data and main-memory
// transactions are queued by the stimulus and compared by a separate monitor.
module tb_mem_write_buffer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ramREN = 1'b0;
    logic        ramWEN = 1'b0;
    logic [31:0] ramaddr = '0;
    logic [31:0] ramstore = '0;
    logic [31:0] ramload;
    logic        ramBUSY;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy = 1'b1;
    logic        wb_empty;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_op_t;

    mem_op_t     q_mem [$];
    logic [31:0] q_rd  [$];
    int          n_vec = 0;
    int          n_err = 0;

    mem_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramBUSY   (ramBUSY),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .wb_empty  (wb_empty)
    );

    always #5 CLK = ~CLK;

    // Main memory returns a fixed pattern derived from the address.
    assign mem_rdata = 32'hDEAD_0000 | {16'h0, mem_addr[15:0]};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
        mem_op_t op;
        op.wen   = wen;
        op.addr  = a;
        op.wdata = d;
        q_mem.push_back(op);
    endtask

    // Monitor: compares memory requests and completed reads against the queues.
    always @(negedge CLK) begin
        if (!RST) begin
            if (mem_en) begin
                if (q_mem.size() == 0) begin
                    check("mem_unexpected_en", 64'(mem_en), 64'd0);
                end else begin
                    check("mem_wen", 64'(mem_wen), 64'(q_mem[0].wen));
                    check("mem_addr", 64'(mem_addr), 64'(q_mem[0].addr));
                    if (q_mem[0].wen != 4'h0)
                        check("mem_wdata", 64'(mem_wdata), 64'(q_mem[0].wdata));
                    if (!mem_busy) void'(q_mem.pop_front());
                end
            end else begin
                check("mem_wen_idle", 64'(mem_wen), 64'd0);
            end
            if (ramREN) begin
                if (!ramBUSY) begin
                    if (q_rd.size() == 0) check("rd_unexpected", 64'(ramBUSY), 64'd1);
                    else check("rd_data", 64'(ramload), 64'(q_rd.pop_front()));
                end
            end else if (!ramWEN) begin
                check("idle_busy", 64'(ramBUSY), 64'd0);
                check("idle_load", 64'(ramload), 64'd0);
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output int waits);
        waits    = 0;
        ramWEN   = 1'b1;
        ramaddr  = a;
        ramstore = d;
        @(negedge CLK);
        while (ramBUSY && waits < 40) begin
            waits++;
            @(negedge CLK);
        end
        if (ramBUSY) check("wr_timeout", 64'(ramBUSY), 64'd0);
        @(posedge CLK);
        #1;
        ramWEN = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic also_w,
                      input logic [31:0] wd, output int waits);
        waits = 0;
        q_rd.push_back(exp);
        ramREN   = 1'b1;
        ramWEN   = also_w;
        ramaddr  = a;
        ramstore = wd;
        @(negedge CLK);
        while (ramBUSY && waits < 40) begin
            waits++;
            @(negedge CLK);
        end
        if (ramBUSY) check("rd_timeout", 64'(ramBUSY), 64'd0);
        @(posedge CLK);
        #1;
        ramREN = 1'b0;
        ramWEN = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        @(negedge CLK);
        while (!wb_empty && n < 100) begin
            n++;
            @(negedge CLK);
        end
        if (!wb_empty) check("empty_timeout", 64'(wb_empty), 64'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic drain_all();
        mem_busy = 1'b0;
        wait_empty();
        mem_busy = 1'b1;
    endtask

    initial begin
        int w;
        int wa [4];
        wa = '{32'h100, 32'h104, 32'h108, 32'h10C};

        // Reset: outputs forced, upstream write not accepted.
        ramWEN   = 1'b1;
        ramaddr  = 32'h99;
        ramstore = 32'h1234;
        @(negedge CLK);
        check("rst_busy", 64'(ramBUSY), 64'd1);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_wen", 64'(mem_wen), 64'd0);
        check("rst_load", 64'(ramload), 64'd0);
        check("rst_wb_empty", 64'(wb_empty), 64'd1);
        @(posedge CLK);
        #1;
        RST    = 1'b0;
        ramWEN = 1'b0;
        @(negedge CLK);
        check("post_rst_empty", 64'(wb_empty), 64'd1);
        @(posedge CLK);
        #1;

        // Write then read the same address: forwarded with no memory read.
        exp_mem(4'hF, 32'h10, 32'hA);
        wr(32'h10, 32'hA, w);
        check("t1_wr_lat", 64'(w), 64'd0);
        rd(32'h10, 32'hA, 1'b0, 32'h0, w);
        check("t1_rd_lat", 64'(w), 64'd0);
        drain_all();

        // Fill four entries with memory stalled; the fifth waits for one drain.
        foreach (wa[i]) exp_mem(4'hF, wa[i], 32'(i + 1));
        exp_mem(4'hF, 32'h110, 32'd5);
        foreach (wa[i]) begin
            wr(wa[i], 32'(i + 1), w);
            check("t2_fill_lat", 64'(w), 64'd0);
        end
        fork
            wr(32'h110, 32'd5, w);
            begin
                repeat (2) @(posedge CLK);
                #1 mem_busy = 1'b0;
                @(posedge CLK);
                #1 mem_busy = 1'b1;
            end
        join
        check("t2_fifth_stall", 64'(w), 64'd3);
        drain_all();

        // Coalesce into a non-head entry while full: accepted immediately, drained once.
        exp_mem(4'hF, 32'h1C, 32'd5);
        exp_mem(4'hF, 32'h20, 32'd2);
        exp_mem(4'hF, 32'h24, 32'd7);
        exp_mem(4'hF, 32'h28, 32'd8);
        wr(32'h1C, 32'd5, w);
        wr(32'h20, 32'd1, w);
        wr(32'h24, 32'd7, w);
        wr(32'h28, 32'd8, w);
        wr(32'h20, 32'd2, w);
        check("t3_coalesce_full", 64'(w), 64'd0);
        drain_all();

        // Write to the head being drained allocates; a read returns the youngest copy.
        exp_mem(4'hF, 32'h50, 32'd1);
        exp_mem(4'hF, 32'h50, 32'd2);
        wr(32'h50, 32'd1, w);
        @(posedge CLK);
        #1;
        wr(32'h50, 32'd2, w);
        check("t7_head_alloc", 64'(w), 64'd0);
        rd(32'h50, 32'd2, 1'b0, 32'h0, w);
        check("t7_youngest", 64'(w), 64'd0);
        drain_all();

        // Read miss beats a pending drain; memory busy for three READ cycles.
        exp_mem(4'h0, 32'h40, 32'h0);
        exp_mem(4'hF, 32'h30, 32'h33);
        wr(32'h30, 32'h33, w);
        fork
            rd(32'h40, 32'hDEAD_0040, 1'b0, 32'h0, w);
            begin
                repeat (4) @(posedge CLK);
                #1 mem_busy = 1'b0;
            end
        join
        check("t4_miss_lat", 64'(w), 64'd4);
        drain_all();

        // Read and write together: read only, nothing buffered.
        mem_busy = 1'b0;
        exp_mem(4'h0, 32'h70, 32'h0);
        rd(32'h70, 32'hDEAD_0070, 1'b1, 32'h77, w);
        check("t11_rd_lat", 64'(w), 64'd1);
        repeat (2) @(negedge CLK);
        check("t11_no_write", 64'(wb_empty), 64'd1);
        @(posedge CLK);
        #1;
        mem_busy = 1'b1;

        // Reset during a drain discards the buffer; a later read goes to memory.
        exp_mem(4'hF, 32'h60, 32'h61);
        wr(32'h60, 32'h61, w);
        wr(32'h64, 32'h65, w);
        wr(32'h68, 32'h69, w);
        RST      = 1'b1;
        mem_busy = 1'b0;
        q_mem.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_mem(4'h0, 32'h64, 32'h0);
        fork
            rd(32'h64, 32'hDEAD_0064, 1'b0, 32'h0, w);
            begin
                @(negedge CLK);
                check("t5_mem_en", 64'(mem_en), 64'd0);
                check("t5_wb_empty", 64'(wb_empty), 64'd1);
                check("t5_busy", 64'(ramBUSY), 64'd1);
            end
        join
        check("t5_rd_lat", 64'(w), 64'd1);
        repeat (3) @(negedge CLK);
        check("t5_no_drain", 64'(wb_empty), 64'd1);

        check("q_mem_left", 64'(q_mem.size()), 64'd0);
        check("q_rd_left", 64'(q_rd.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
